// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single external memory bus between instruction fetch (PC) and
// the MEM-stage load/store unit. A three-state FSM issues one registered bus
// transaction at a time, data port first. Per-port stall requests are raised
// until the access completes. Returned data is held in a per-port buffer
// while the pipeline stage that consumes it is frozen.
//
// Optional feature: define ARB_BUS_TIMEOUT_EN to add a bus watchdog that
// aborts a transaction after TIMEOUT unacknowledged BUSY cycles, returns
// 32'h0 to the waiting port and pulses bus_err_o for one cycle. Without the
// macro a BUSY state waits for bus_ack_i indefinitely and bus_err_o is 0.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_stallreq_o,
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_stallreq_o,
    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] D_BUSY = 2'd1;
    localparam logic [1:0] I_BUSY = 2'd2;

    logic [1:0]  state;
    logic        i_hold, d_hold;
    logic [31:0] i_buf, d_buf;

    logic        live;
    logic        i_pend, d_pend;
    logic        i_ack, d_ack;
    logic        i_tmo, d_tmo;
    logic        i_done, d_done;
    logic [31:0] i_fwd, d_fwd;

    // A flush (or reset) discards any completion seen in the same cycle.
    assign live   = ~rst & ~flush_i;

    // A held access is complete; it must not be issued again.
    assign i_pend = if_ce_i & ~i_hold;
    assign d_pend = d_ce_i & ~d_hold;

    assign i_ack  = live & (state == I_BUSY) & bus_ack_i;
    assign d_ack  = live & (state == D_BUSY) & bus_ack_i;

`ifdef ARB_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt;
    logic       wd_hit;

    // Expiry happens in the TIMEOUT-th unacknowledged BUSY cycle.
    assign wd_hit = live & (state != IDLE) & ~bus_ack_i & (wd_cnt == TIMEOUT_LAST);
    assign i_tmo  = wd_hit & (state == I_BUSY);
    assign d_tmo  = wd_hit & (state == D_BUSY);

    // Watchdog: count unacknowledged BUSY cycles and flag expiry one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= wd_hit;
            if (state == IDLE)
                wd_cnt <= '0;
            else if (!bus_ack_i)
                wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign i_tmo     = 1'b0;
    assign d_tmo     = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // A timed-out access completes like an ack but returns zero.
    assign i_done = i_ack | i_tmo;
    assign d_done = d_ack | d_tmo;
    assign i_fwd  = i_tmo ? 32'h0 : bus_rdata_i;
    assign d_fwd  = d_tmo ? 32'h0 : bus_rdata_i;

    assign if_stallreq_o = live & i_pend & ~i_done;
    assign d_stallreq_o  = live & d_pend & ~d_done;

    // Read data is forwarded in the completion cycle so the stall can drop at once.
    assign if_inst_o = i_done ? i_fwd : i_buf;
    assign d_rdata_o = d_done ? d_fwd : d_buf;

    // Arbitration FSM and registered bus outputs; bus fields load only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state       <= IDLE;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
        end else if (flush_i) begin
            state     <= IDLE;
            bus_cyc_o <= 1'b0;
            bus_we_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_pend) begin
                        state       <= D_BUSY;
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= d_we_i;
                        bus_sel_o   <= d_sel_i;
                        bus_addr_o  <= d_addr_i;
                        bus_wdata_o <= d_wdata_i;
                    end else if (i_pend) begin
                        state       <= I_BUSY;
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'hF;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= 32'h0;
                    end
                end
                D_BUSY: begin
                    if (d_done) begin
                        state     <= IDLE;
                        bus_cyc_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                    end
                end
                I_BUSY: begin
                    if (i_done) begin
                        state     <= IDLE;
                        bus_cyc_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_cyc_o <= 1'b0;
                    bus_we_o  <= 1'b0;
                end
            endcase
        end
    end

    // Fetch port: capture returned data and hold it while IF/ID is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_buf  <= 32'h0;
            i_hold <= 1'b0;
        end else begin
            if (i_done)
                i_buf <= i_fwd;
            if (flush_i)
                i_hold <= 1'b0;
            else if (i_done && stall_i[1])
                i_hold <= 1'b1;
            else if (!stall_i[1])
                i_hold <= 1'b0;
        end
    end

    // Data port: capture returned data and hold it while MEM/WB is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_buf  <= 32'h0;
            d_hold <= 1'b0;
        end else begin
            if (d_done)
                d_buf <= d_fwd;
            if (flush_i)
                d_hold <= 1'b0;
            else if (d_done && stall_i[4])
                d_hold <= 1'b1;
            else if (!stall_i[4])
                d_hold <= 1'b0;
        end
    end

endmodule
